// File: rtl/mul_arb_pkg.sv
// Shared types and the round-robin pick used by the two-requester multiply arbiter.
package mul_arb_pkg;

  localparam int N_REQ = 2;

  typedef logic             req_id_t;
  typedef logic [N_REQ-1:0] req_vec_t;

  // On contention, the requester not served at the last transfer wins.
  function automatic req_id_t rr_pick(input req_vec_t vld, input req_id_t last);
    req_id_t pick;
    if (vld == 2'b11) pick = ~last;
    else if (vld[1])  pick = 1'b1;
    else              pick = 1'b0;
    return pick;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Request/result bus of the multiply arbiter: two operand requesters in, one product stream out.
interface mul_arbiter_if #(parameter int n = 8) ();
  import mul_arb_pkg::*;

  // Handshake: a transfer happens on any rising edge where valid && ready are both
  // high; a source holds valid and payload stable until that edge, and ready may
  // depend combinationally on valid.
  req_vec_t           req_vld;
  req_vec_t           req_rdy;
  logic [n-1:0]       req_a0;
  logic [n-1:0]       req_b0;
  logic [n-1:0]       req_a1;
  logic [n-1:0]       req_b1;
  req_vec_t           req_signed;
  logic               res_vld;
  logic               res_rdy;
  logic [2*n-1:0]     res;
  req_id_t            res_id;

  modport master (
    output req_vld, req_a0, req_b0, req_a1, req_b1, req_signed, res_rdy,
    input  req_rdy, res_vld, res, res_id
  );

  modport slave (
    input  req_vld, req_a0, req_b0, req_a1, req_b1, req_signed, res_rdy,
    output req_rdy, res_vld, res, res_id
  );

endinterface

// File: rtl/signed_or_unsigned_mul.sv
// Combinational n x n multiplier giving the exact 2n-bit product in signed or unsigned mode.
module signed_or_unsigned_mul #(
  parameter int n = 8
) (
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic           is_signed,
  output logic [2*n-1:0] p
);

  logic [2*n-1:0] a_ext;
  logic [2*n-1:0] b_ext;

  // Extending to the full product width makes the low 2n bits exact in both modes.
  always_comb begin
    a_ext = is_signed ? {{n{a[n-1]}}, a} : {{n{1'b0}}, a};
    b_ext = is_signed ? {{n{b[n-1]}}, b} : {{n{1'b0}}, b};
    p     = a_ext * b_ext;
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter feeding a two-stage multiply pipeline (operands, then product).
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int n = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_arbiter_if.slave  bus
);

  logic           s1_vld_q, s1_vld_d;
  logic [n-1:0]   s1_a_q, s1_a_d;
  logic [n-1:0]   s1_b_q, s1_b_d;
  logic           s1_sgn_q, s1_sgn_d;
  req_id_t        s1_id_q, s1_id_d;
  logic           s2_vld_q, s2_vld_d;
  logic [2*n-1:0] s2_res_q, s2_res_d;
  req_id_t        s2_id_q, s2_id_d;
  req_id_t        last_q, last_d;

  logic           s2_free;
  logic           s1_free;
  logic           take;
  req_id_t        grant;
  req_vec_t       rdy;
  logic [2*n-1:0] prod;

  signed_or_unsigned_mul #(.n(n)) u_mul (
    .a         (s1_a_q),
    .b         (s1_b_q),
    .is_signed (s1_sgn_q),
    .p         (prod)
  );

  // Stage 1 may load when empty or when its content moves into stage 2 this cycle.
  always_comb begin
    s2_free = !s2_vld_q || bus.res_rdy;
    s1_free = !s1_vld_q || s2_free;
    grant   = rr_pick(bus.req_vld, last_q);
    take    = rst_n && s1_free && (bus.req_vld != '0);
    rdy     = '0;
    if (take) rdy[grant] = 1'b1;
  end

  always_comb begin
    last_d   = take ? grant : last_q;
    s1_vld_d = s1_vld_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_sgn_d = s1_sgn_q;
    s1_id_d  = s1_id_q;
    if (take) begin
      s1_vld_d = 1'b1;
      s1_a_d   = grant ? bus.req_a1 : bus.req_a0;
      s1_b_d   = grant ? bus.req_b1 : bus.req_b0;
      s1_sgn_d = bus.req_signed[grant];
      s1_id_d  = grant;
    end else if (s2_free) begin
      s1_vld_d = 1'b0;
    end

    s2_vld_d = s2_vld_q;
    s2_res_d = s2_res_q;
    s2_id_d  = s2_id_q;
    if (s2_free) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_res_d = prod;
        s2_id_d  = s1_id_q;
      end
    end
  end

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_sgn_q <= 1'b0;
      s1_id_q  <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_res_q <= '0;
      s2_id_q  <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_sgn_q <= s1_sgn_d;
      s1_id_q  <= s1_id_d;
      s2_vld_q <= s2_vld_d;
      s2_res_q <= s2_res_d;
      s2_id_q  <= s2_id_d;
      last_q   <= last_d;
    end
  end

  assign bus.req_rdy = rdy;
  assign bus.res_vld = s2_vld_q;
  assign bus.res     = s2_res_q;
  assign bus.res_id  = s2_id_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed and randomised bench for mul_arbiter at n=4 with an in-order result scoreboard.
module tb_mul_arbiter;
  import mul_arb_pkg::*;

  localparam int N = 4;

  logic clk;
  logic rst_n;

  mul_arbiter_if #(.n(N)) bus ();

  mul_arbiter #(.n(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         total;
  int         bad;
  int         res_cnt;
  int         nxt;
  int         lim;
  logic [8:0] exp_q[$];
  logic       acc_ids[$];

  logic [3:0] a_tab [8] = '{4'h8, 4'h7, 4'hF, 4'h3, 4'h9, 4'h0, 4'hC, 4'h5};
  logic [3:0] b_tab [8] = '{4'h8, 4'hF, 4'hF, 4'hD, 4'h6, 4'hA, 4'h4, 4'h5};
  logic       s_tab [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required finish before 500us");
    $fatal(1);
  end

  // A waiting requester must keep valid and operands until accepted.
  logic [1:0] pend;
  logic [3:0] pa0, pb0, pa1, pb1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 2'b00;
    end else begin
      if (pend[0] && !(bus.req_vld[0] && bus.req_a0 == pa0 && bus.req_b0 == pb0))
        $error("requester 0 dropped or changed a waiting request");
      if (pend[1] && !(bus.req_vld[1] && bus.req_a1 == pa1 && bus.req_b1 == pb1))
        $error("requester 1 dropped or changed a waiting request");
      pend <= bus.req_vld & ~bus.req_rdy;
      pa0  <= bus.req_a0;
      pb0  <= bus.req_b0;
      pa1  <= bus.req_a1;
      pb1  <= bus.req_b1;
    end
  end

  // ---------------- model ----------------
  function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ia, ib, p;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    return p[7:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge after inputs are set; books transfers then advances one cycle.
  task automatic cycle();
    logic [8:0] e;
    #2;
    total++;
    if (bus.req_rdy == 2'b11 || (bus.req_rdy & ~bus.req_vld) != 2'b00) begin
      bad++;
      $display("FAIL grant_legal req_rdy=%b req_vld=%b required one-hot subset of valid", bus.req_rdy, bus.req_vld);
    end
    if (bus.req_vld[0] && bus.req_rdy[0]) begin
      exp_q.push_back({1'b0, golden(bus.req_a0, bus.req_b0, bus.req_signed[0])});
      acc_ids.push_back(1'b0);
    end
    if (bus.req_vld[1] && bus.req_rdy[1]) begin
      exp_q.push_back({1'b1, golden(bus.req_a1, bus.req_b1, bus.req_signed[1])});
      acc_ids.push_back(1'b1);
    end
    if (bus.res_vld && bus.res_rdy) begin
      total++;
      res_cnt++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got id=%0d res=%h required no result", bus.res_id, bus.res);
      end else begin
        e = exp_q.pop_front();
        if ({bus.res_id, bus.res} !== e) begin
          bad++;
          $display("FAIL sb_result got id=%0d res=%h required id=%0d res=%h", bus.res_id, bus.res, e[8], e[7:0]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic load(input int i, input int k);
    if (i == 0) begin
      bus.req_a0        = a_tab[k % 8];
      bus.req_b0        = b_tab[k % 8];
      bus.req_signed[0] = s_tab[k % 8];
    end else begin
      bus.req_a1        = a_tab[k % 8];
      bus.req_b1        = b_tab[k % 8];
      bus.req_signed[1] = s_tab[k % 8];
    end
    bus.req_vld[i] = 1'b1;
  endtask

  task automatic refill(input logic [1:0] g);
    for (int i = 0; i < 2; i++) begin
      if (g[i]) begin
        if (nxt < lim) begin
          load(i, nxt);
          nxt++;
        end else begin
          bus.req_vld[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    bus.req_vld = 2'b00;
    bus.res_rdy = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d required 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req_vld = 2'b11;
    #1;
    total++;
    if (bus.req_rdy !== 2'b00) begin
      bad++; $display("FAIL reset_rdy got %b required 00", bus.req_rdy);
    end
    total++;
    if (bus.res_vld !== 1'b0 || bus.res !== 8'h00 || bus.res_id !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got vld=%b res=%h id=%b required 0/00/0", bus.res_vld, bus.res, bus.res_id);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    bus.req_vld = 2'b00;
  endtask

  task automatic test_signed_min();
    bus.req_a0 = 4'h8; bus.req_b0 = 4'h8; bus.req_signed = 2'b01;
    bus.req_vld = 2'b01; bus.res_rdy = 1'b1;
    #1;
    total++;
    if (bus.req_rdy !== 2'b01) begin
      bad++; $display("FAIL first_accept got %b required 01", bus.req_rdy);
    end
    cycle();
    bus.req_vld = 2'b00;
    #1;
    total++;
    if (bus.res_vld !== 1'b0) begin
      bad++; $display("FAIL latency_early got res_vld=%b required 0", bus.res_vld);
    end
    cycle();
    #1;
    total++;
    if (bus.res_vld !== 1'b1 || bus.res !== 8'h40 || bus.res_id !== 1'b0) begin
      bad++; $display("FAIL signed_min got vld=%b res=%h id=%b required 1/40/0", bus.res_vld, bus.res, bus.res_id);
    end
    cycle();
    #1;
    total++;
    if (bus.res_vld !== 1'b0) begin
      bad++; $display("FAIL single_result got res_vld=%b required 0", bus.res_vld);
    end
    drain();
  endtask

  task automatic test_req1_modes();
    bus.req_a1 = 4'hF; bus.req_b1 = 4'hF; bus.req_signed = 2'b00;
    bus.req_vld = 2'b10;
    #1;
    total++;
    if (bus.req_rdy !== 2'b10) begin
      bad++; $display("FAIL req1_accept got %b required 10", bus.req_rdy);
    end
    cycle();
    bus.req_signed = 2'b10;
    #1;
    total++;
    if (bus.req_rdy !== 2'b10) begin
      bad++; $display("FAIL req1_back_to_back got %b required 10", bus.req_rdy);
    end
    cycle();
    bus.req_vld = 2'b00;
    #1;
    total++;
    if (bus.res_vld !== 1'b1 || bus.res !== 8'hE1 || bus.res_id !== 1'b1) begin
      bad++; $display("FAIL unsigned_max got vld=%b res=%h id=%b required 1/e1/1", bus.res_vld, bus.res, bus.res_id);
    end
    cycle();
    #1;
    total++;
    if (bus.res_vld !== 1'b1 || bus.res !== 8'h01 || bus.res_id !== 1'b1) begin
      bad++; $display("FAIL signed_neg1 got vld=%b res=%h id=%b required 1/01/1", bus.res_vld, bus.res, bus.res_id);
    end
    cycle();
    drain();
  endtask

  task automatic test_contention();
    logic [1:0] g;
    logic       want;
    acc_ids.delete();
    nxt = 0; lim = 8;
    load(0, nxt); nxt++;
    load(1, nxt); nxt++;
    bus.res_rdy = 1'b1;
    for (int c = 0; c < 20 && acc_ids.size() < 8; c++) begin
      #1;
      g = bus.req_rdy;
      total++;
      if (g == 2'b00) begin
        bad++; $display("FAIL contend_stall cycle=%0d got req_rdy=00 required a grant", c);
      end
      cycle();
      refill(g);
    end
    total++;
    if (acc_ids.size() != 8) begin
      bad++; $display("FAIL contend_count got %0d required 8", acc_ids.size());
    end
    for (int k = 0; k < acc_ids.size(); k++) begin
      want = ((k % 2) == 1);
      total++;
      if (acc_ids[k] !== want) begin
        bad++; $display("FAIL contend_order slot=%0d got %b required %b", k, acc_ids[k], want);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    logic [8:0] held;
    held = '0;
    acc_ids.delete();
    nxt = 0; lim = 4;
    load(0, nxt); nxt++;
    load(1, nxt); nxt++;
    bus.res_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      g = bus.req_rdy;
      if (c == 2) held = {bus.res_id, bus.res};
      if (c >= 2) begin
        total++;
        if (g !== 2'b00) begin
          bad++; $display("FAIL bp_rdy cycle=%0d got %b required 00", c, g);
        end
        total++;
        if (bus.res_vld !== 1'b1 || {bus.res_id, bus.res} !== held) begin
          bad++; $display("FAIL bp_hold cycle=%0d got vld=%b %h required 1 %h", c, bus.res_vld, {bus.res_id, bus.res}, held);
        end
      end
      cycle();
      refill(g);
    end
    total++;
    if (acc_ids.size() != 2) begin
      bad++; $display("FAIL bp_inflight got %0d required 2", acc_ids.size());
    end
    bus.res_rdy = 1'b1;
    #1;
    total++;
    if (bus.req_rdy == 2'b00) begin
      bad++; $display("FAIL bp_resume got req_rdy=00 required a grant");
    end
    for (int c = 0; c < 20 && acc_ids.size() < 4; c++) begin
      g = bus.req_rdy;
      cycle();
      refill(g);
      #1;
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    logic [1:0] g;
    nxt = 0; lim = 4;
    load(0, nxt); nxt++;
    load(1, nxt); nxt++;
    bus.res_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      g = bus.req_rdy;
      cycle();
      refill(g);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.res_vld !== 1'b0 || bus.res !== 8'h00 || bus.req_rdy !== 2'b00) begin
      bad++; $display("FAIL async_reset got vld=%b res=%h rdy=%b required 0/00/00", bus.res_vld, bus.res, bus.req_rdy);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_rdy = 1'b1;
    #1;
    total++;
    if (bus.req_rdy !== 2'b01) begin
      bad++; $display("FAIL post_reset_grant got %b required 01", bus.req_rdy);
    end
    g = bus.req_rdy;
    cycle();
    refill(g);
    #1;
    total++;
    if (bus.res_vld !== 1'b0) begin
      bad++; $display("FAIL stale_result got res_vld=%b required 0", bus.res_vld);
    end
    g = bus.req_rdy;
    cycle();
    refill(g);
    drain();
  endtask

  task automatic test_random();
    int         issued;
    int         start;
    int         cyc;
    logic [1:0] g;
    logic [8:0] op;
    issued = 0;
    start  = res_cnt;
    cyc    = 0;
    bus.req_vld = 2'b00;
    while ((issued < 512 || bus.req_vld != 2'b00 || exp_q.size() != 0) && cyc < 6000) begin
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_vld[i] && issued < 512 && $urandom_range(0, 3) != 0) begin
          op = issued[8:0];
          if (i == 0) begin bus.req_a0 = op[3:0]; bus.req_b0 = op[7:4]; end
          else        begin bus.req_a1 = op[3:0]; bus.req_b1 = op[7:4]; end
          bus.req_signed[i] = op[8];
          bus.req_vld[i]    = 1'b1;
          issued++;
        end else if (bus.req_vld[i] && $urandom_range(0, 7) == 0) begin
          bus.req_signed[i] = ~bus.req_signed[i];
        end
      end
      bus.res_rdy = ($urandom_range(0, 3) != 0);
      #1;
      g = bus.req_rdy;
      cycle();
      for (int i = 0; i < 2; i++) if (g[i]) bus.req_vld[i] = 1'b0;
      cyc++;
    end
    total++;
    if (res_cnt - start != 512) begin
      bad++; $display("FAIL random_count got %0d results required 512", res_cnt - start);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    total = 0; bad = 0; res_cnt = 0; nxt = 0; lim = 0;
    rst_n          = 1'b0;
    bus.req_vld    = 2'b00;
    bus.req_a0     = '0;
    bus.req_b0     = '0;
    bus.req_a1     = '0;
    bus.req_b1     = '0;
    bus.req_signed = 2'b00;
    bus.res_rdy    = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_signed_min();
    test_req1_modes();
    test_contention();
    test_backpressure();
    test_reset_inflight();
    test_random();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: n, default 8, operand width in bits.
REQ-002 Port: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req_vld  input  2  per-requester request valid, bit i = requester i.
REQ-005 Port: req_rdy  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 Port: req_a0, req_b0  input  n each  requester 0 operands.
REQ-007 Port: req_a1, req_b1  input  n each  requester 1 operands.
REQ-008 Port: req_signed  input  2  per-requester mode: 1 = signed multiply, 0 = unsigned.
REQ-009 Port: res_vld  output  1  result valid.
REQ-010 Port: res_rdy  input  1  downstream accept.
REQ-011 Port: res  output  2n  product.
REQ-012 Port: res_id  output  1  index of the requester that issued the operation.

Function
REQ-013 A request transfer SHALL occur on a cycle with req_vld[i] && req_rdy[i]; a result transfer SHALL occur on a cycle with res_vld && res_rdy.
REQ-014 Arbitration SHALL be two-way round-robin: when both are valid, grant the requester not granted at the last transfer; a single valid requester is granted immediately.
REQ-015 The last-grant pointer SHALL update only on a request transfer; after reset requester 0 wins the first contention.
REQ-016 req_rdy[i] SHALL be high only when requester i is granted and stage 1 can accept (stage 1 empty or advancing this cycle); req_rdy SHALL NOT depend on res_vld of the same requester.
REQ-017 Pipeline: stage 1 registers a, b, mode, id; stage 2 registers the 2n-bit product, id; res_vld is stage-2 valid.
REQ-018 Latency: a request accepted at cycle t with res_rdy held high SHALL present res_vld at cycle t+2.
REQ-019 Throughput: with res_rdy high, one transfer per cycle sustained; contending requesters SHALL alternate 0,1,0,1.
REQ-020 Backpressure: when res_vld && !res_rdy, stage 2 SHALL hold res, res_id, res_vld stable; stage 1 SHALL advance only if stage 2 is empty or draining; at most 2 operations in flight.
REQ-021 Signed mode: operands sign-extended to 2n bits, res = exact 2n-bit two's-complement product; unsigned mode: zero-extended, exact unsigned product.
REQ-022 Boundary: signed min*min (n=4: -8*-8) SHALL yield +64 without overflow; unsigned max*max (15*15) SHALL yield 225.
REQ-023 Mode SHALL be captured per operation at acceptance; requesters changing req_signed while waiting SHALL not affect in-flight results.
REQ-024 Results SHALL be returned in acceptance order; no operation dropped or duplicated.
REQ-025 A requester SHALL hold req_vld and operands stable until accepted (protocol assumption checked by bench assertion).

Reset
REQ-026 On rst_n low, asynchronously: stage valids cleared, res_vld = 0, res = 0, res_id = 0, last-grant pointer = 1 (so requester 0 wins next).
REQ-027 req_rdy SHALL be 0 while rst_n is low; in-flight operations SHALL be discarded without producing results.
REQ-028 First request may be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package mul_arb_pkg SHALL hold localparam N_REQ = 2 and typedef req_id_t (1-bit requester index).
REQ-030 The multiply SHALL be a combinational sub-module instance, signed_or_unsigned_mul #(n), between stage 1 and stage 2 registers; arbitration and pipeline control stay in mul_arbiter.

Verification
REQ-031 n=4, only req 0 valid, a=4'h8, b=4'h8, signed=1, res_rdy=1 -> res=8'h40, res_id=0, exactly 2 cycles after accept.
REQ-032 n=4, only req 1 valid, a=4'hF, b=4'hF, signed=0 -> res=8'hE1, res_id=1; same operands signed=1 -> res=8'h01.
REQ-033 Both valid continuously after reset, res_rdy=1 -> accepts 0,1,0,1...; res_id sequence 0,1,0,1 matching per-requester golden products.
REQ-034 res_rdy=0 for 5 cycles with both valid -> exactly 2 ops accepted, res held stable, req_rdy=0 thereafter; res_rdy=1 -> both results drain in order, acceptance resumes.
REQ-035 rst_n pulsed low with 2 ops in flight -> res_vld=0 immediately (asynchronously), no stale result after release; next contention granted to requester 0.
REQ-036 Random stimulus, all n=4 operand pairs, both modes, random res_rdy -> scoreboard match against signed/unsigned golden model, no loss or reordering.
